coin_credit_manager: RTL and testbench

COIN_CREDIT_MANAGER -- requirements
Module: coin_credit_manager

---
 rtl/coin_credit_manager.sv | 164 ++++++++++++++++
 tb/tb_coin_credit_manager.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/coin_credit_manager.sv
// coin_credit_manager
//   Tracks customer credit in cents. Accepts coins and deducts purchase prices
//   while IDLE. On cancel, it pays the credit back one coin per cycle in
//   CHANGE, using the largest coin first.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous reset, active low
//   coin_valid    in   one-cycle pulse, coin offered
//   coin_type     in   [1:0] 00=5 01=10 10=25 11=100 cents
//   cancel        in   one-cycle pulse, return all credit
//   apple/banana/carrot/date  in  dispense pulses (prices 75/20/30/40)
//   credit        out  [7:0] registered credit in cents
//   coin_reject   out  registered pulse, offered coin not taken
//   underflow_err out  registered pulse, price exceeded credit
//   change_valid  out  registered pulse, one per change coin
//   change_coin   out  [1:0] 00=5 01=10 10=25, qualified by change_valid
//   busy          out  high while in CHANGE
//
// Configuration
//   AUTO_CHANGE_EN  when defined, a dispense that leaves credit > 0 goes
//                   straight to CHANGE and returns the remainder.
module coin_credit_manager (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic       apple,
  input  logic       banana,
  input  logic       carrot,
  input  logic       date,
  output logic [7:0] credit,
  output logic       coin_reject,
  output logic       underflow_err,
  output logic       change_valid,
  output logic [1:0] change_coin,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, CHANGE = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       coin_reject_q, coin_reject_d;
  logic       underflow_err_q, underflow_err_d;
  logic       change_valid_q, change_valid_d;
  logic [1:0] change_coin_q, change_coin_d;

  logic [7:0] coin_val;
  logic [8:0] coin_sum;
  logic [7:0] price;
  logic       disp_any;
  logic [7:0] chg_val;
  logic [1:0] chg_code;

  always_comb begin
    case (coin_type)
      2'b00:   coin_val = 8'd5;
      2'b01:   coin_val = 8'd10;
      2'b10:   coin_val = 8'd25;
      default: coin_val = 8'd100;
    endcase
  end

  // Ninth bit catches any sum above 255.
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

  // Only the highest-priority dispense is charged.
  always_comb begin
    disp_any = apple | banana | carrot | date;
    if (apple)       price = 8'd75;
    else if (banana) price = 8'd20;
    else if (carrot) price = 8'd30;
    else if (date)   price = 8'd40;
    else             price = 8'd0;
  end

  // Greedy change: the largest coin that still fits. Credit is always a
  // multiple of 5, so the 5-cent fallback always fits when credit is nonzero.
  always_comb begin
    if (credit_q >= 8'd25) begin
      chg_val  = 8'd25;
      chg_code = 2'b10;
    end else if (credit_q >= 8'd10) begin
      chg_val  = 8'd10;
      chg_code = 2'b01;
    end else begin
      chg_val  = 8'd5;
      chg_code = 2'b00;
    end
  end

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    coin_reject_d   = 1'b0;
    underflow_err_d = 1'b0;
    change_valid_d  = 1'b0;
    change_coin_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (cancel && credit_q != 8'd0) begin
          // Cancel overrides a dispense and a coin in the same cycle.
          state_d       = CHANGE;
          coin_reject_d = coin_valid;
        end else if (disp_any) begin
          // A coin arriving with a dispense is always bounced.
          coin_reject_d = coin_valid;
          if (price > credit_q) begin
            underflow_err_d = 1'b1;
          end else begin
            credit_d = credit_q - price;
`ifdef AUTO_CHANGE_EN
            if (credit_q != price) state_d = CHANGE;
`endif
          end
        end else if (coin_valid) begin
          if (coin_sum[8]) coin_reject_d = 1'b1;
          else             credit_d      = coin_sum[7:0];
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (credit_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          change_valid_d = 1'b1;
          change_coin_d  = chg_code;
          credit_d       = credit_q - chg_val;
          // Leave on the edge that pays out the last coin.
          if (credit_q == chg_val) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      credit_q        <= 8'd0;
      coin_reject_q   <= 1'b0;
      underflow_err_q <= 1'b0;
      change_valid_q  <= 1'b0;
      change_coin_q   <= 2'b00;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      coin_reject_q   <= coin_reject_d;
      underflow_err_q <= underflow_err_d;
      change_valid_q  <= change_valid_d;
      change_coin_q   <= change_coin_d;
    end
  end

  assign credit        = credit_q;
  assign coin_reject   = coin_reject_q;
  assign underflow_err = underflow_err_q;
  assign change_valid  = change_valid_q;
  assign change_coin   = change_coin_q;
  assign busy          = (state_q == CHANGE);

endmodule

// File: tb/tb_coin_credit_manager.sv
// Directed bench for coin_credit_manager. Inputs change 1 time unit after a
// rising edge, and outputs are sampled at that same point.
module tb_coin_credit_manager;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;
  logic       apple, banana, carrot, date;
  logic [7:0] credit;
  logic       coin_reject, underflow_err, change_valid, busy;
  logic [1:0] change_coin;

  int checks   = 0;
  int failures = 0;

  coin_credit_manager dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .apple(apple), .banana(banana), .carrot(carrot),
    .date(date), .credit(credit), .coin_reject(coin_reject),
    .underflow_err(underflow_err), .change_valid(change_valid),
    .change_coin(change_coin), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    coin_valid = 0; coin_type = 0; cancel = 0;
    apple = 0; banana = 0; carrot = 0; date = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  // Insert one coin with no other inputs active.
  task automatic coin(input logic [1:0] t);
    coin_valid = 1; coin_type = t;
    tick();
  endtask

  // Expect one change coin on the cycle just sampled.
  task automatic chg(input string tag, input int code, input int cr, input int bz);
    chk({tag, "_cv"}, change_valid, 1);
    chk({tag, "_cc"}, change_coin, code);
    chk({tag, "_cr"}, credit, cr);
    chk({tag, "_bz"}, busy, bz);
  endtask

  initial begin
    clr();
    reset = 0;
    #1;
    // Reset: inputs are ignored while reset is low.
    coin_valid = 1; coin_type = 2'b11;
    tick();
    tick();
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cv", change_valid, 0);
    chk("rst_cc", change_coin, 0);
    chk("rst_rej", coin_reject, 0);
    chk("rst_uf", underflow_err, 0);
    reset = 1;

    // 25, 25, 25, then apple.
    coin(2'b10); chk("c25_a", credit, 25); chk("c25_rej", coin_reject, 0);
    coin(2'b10); chk("c25_b", credit, 50);
    coin(2'b10); chk("c25_c", credit, 75);
    apple = 1; tick();
    chk("apple_cr", credit, 0); chk("apple_uf", underflow_err, 0);
    chk("apple_bz", busy, 0);

    // Overflow: 200 + 100 is rejected.
    coin(2'b11); coin(2'b11); chk("c200", credit, 200);
    coin(2'b11);
    chk("ovf_rej", coin_reject, 1); chk("ovf_cr", credit, 200);
    tick(); chk("ovf_rej_clr", coin_reject, 0);

    // Underflow: 20 with carrot (30).
    reset = 0; tick(); reset = 1;
    chk("rst2_cr", credit, 0);
    coin(2'b01); coin(2'b01); chk("c20", credit, 20);
    carrot = 1; tick();
    chk("uf_pulse", underflow_err, 1); chk("uf_cr", credit, 20);
    tick(); chk("uf_clr", underflow_err, 0);

    // 65 cents returned as 25, 25, 10, 5.
    coin(2'b10); coin(2'b01); coin(2'b01); chk("c65", credit, 65);
    cancel = 1; tick();
    chk("cn_bz", busy, 1); chk("cn_cv", change_valid, 0); chk("cn_cr", credit, 65);
    tick(); chg("ch1", 2, 40, 1);
    tick(); chg("ch2", 2, 15, 1);
    tick(); chg("ch3", 1, 5, 1);
    tick(); chg("ch4", 0, 0, 0);
    tick(); chk("ch_end_cv", change_valid, 0); chk("ch_end_bz", busy, 0);

    // Priority: apple wins over banana and date at 75.
    coin(2'b10); coin(2'b10); coin(2'b10);
    apple = 1; banana = 1; date = 1; tick();
    chk("prio_cr", credit, 0); chk("prio_uf", underflow_err, 0);

    // A coin arriving with a dispense is rejected and the dispense is charged.
    coin(2'b01); coin(2'b01);
    banana = 1; coin_valid = 1; coin_type = 2'b10; tick();
    chk("cd_cr", credit, 0); chk("cd_rej", coin_reject, 1);

    // Cancel with zero credit is ignored.
    cancel = 1; tick();
    chk("cn0_bz", busy, 0); chk("cn0_cr", credit, 0);

    // Cancel overrides a same-cycle coin and dispense; coins offered in CHANGE are rejected.
    coin(2'b01); chk("c10", credit, 10);
    cancel = 1; date = 1; coin_valid = 1; coin_type = 2'b10; tick();
    chk("cnp_bz", busy, 1); chk("cnp_cr", credit, 10); chk("cnp_rej", coin_reject, 1);
    coin_valid = 1; coin_type = 2'b11; apple = 1; tick();
    chg("cnp_ch", 1, 0, 0); chk("chg_rej", coin_reject, 1);
    tick(); chk("cnp_end_cv", change_valid, 0);

    // 100 cents then banana.
    coin(2'b11);
    banana = 1; tick();
    chk("ban_cr", credit, 80);
`ifdef AUTO_CHANGE_EN
    chk("ban_bz", busy, 1);
    tick(); chg("ac1", 2, 55, 1);
    tick(); chg("ac2", 2, 30, 1);
    tick(); chg("ac3", 2, 5, 1);
    tick(); chg("ac4", 0, 0, 0);
`else
    chk("ban_bz", busy, 0);
    tick(); tick();
    chk("ban_hold", credit, 80); chk("ban_cv", change_valid, 0);
`endif

    // Reset mid-return aborts the payout.
    reset = 0; tick(); reset = 1;
    coin(2'b10); coin(2'b10); coin(2'b01); coin(2'b00); chk("c65b", credit, 65);
    cancel = 1; tick();
    tick(); chg("ab1", 2, 40, 1);
    reset = 0; tick(); reset = 1;
    chk("ab_cr", credit, 0); chk("ab_cv", change_valid, 0); chk("ab_bz", busy, 0);
    tick();
    chk("ab2_cr", credit, 0); chk("ab2_cv", change_valid, 0); chk("ab2_bz", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
